// File: rtl/np_mem.sv
// np_mem: split instruction/data memory with a loader front end.
// A LOAD/RUN/HALT sequencer holds the CPU in reset while memory is loaded.
module np_mem #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int MEMSIZE  = 1 << ADDRSIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDRSIZE-1:0] in_address,
    input  logic                in_wr,
    input  logic [WIDTH-1:0]    in_dataOut,
    output logic [WIDTH-1:0]    in_dataIn,
    input  logic [ADDRSIZE-1:0] address,
    input  logic                wr,
    input  logic [WIDTH-1:0]    dataOut,
    output logic [WIDTH-1:0]    dataIn,
    input  logic                halt,
    output logic                cpu_reset,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic                ld_target,
    input  logic [ADDRSIZE-1:0] ld_addr,
    input  logic [WIDTH-1:0]    ld_data,
    input  logic                ld_last,
    output logic                done,
    output logic [31:0]         run_cycles
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] imem [MEMSIZE];
    logic [WIDTH-1:0] dmem [MEMSIZE];

    logic                im_we, dm_we;
    logic [ADDRSIZE-1:0] im_wa, dm_wa;
    logic [WIDTH-1:0]    im_wd, dm_wd;

    always_ff @(posedge clk) begin
        if (reset) state <= S_LOAD;
        else       state <= state_nxt;
    end

    // Write ports are steered here so loader and CPU share one port per array.
    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        cpu_reset = 1'b0;
        done      = 1'b0;
        im_we     = 1'b0;
        dm_we     = 1'b0;
        im_wa     = in_address;
        dm_wa     = address;
        im_wd     = in_dataOut;
        dm_wd     = dataOut;
        unique case (state)
            S_LOAD: begin
                ld_ready  = 1'b1;
                cpu_reset = 1'b1;
                im_wa     = ld_addr;
                dm_wa     = ld_addr;
                im_wd     = ld_data;
                dm_wd     = ld_data;
                if (ld_valid) begin
                    im_we = ~ld_target;
                    dm_we = ld_target;
                    if (ld_last) state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                im_we = in_wr;
                dm_we = wr;
                if (halt) state_nxt = S_HALT;
            end
            S_HALT: begin
                done = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            im_we = 1'b0;
            dm_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (im_we) imem[im_wa] <= im_wd;
        if (dm_we) dmem[dm_wa] <= dm_wd;
    end

    // Read-first: the read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_dataIn <= '0;
            dataIn    <= '0;
        end else begin
            in_dataIn <= imem[in_address];
            dataIn    <= dmem[address];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)              run_cycles <= '0;
        else if (state == S_RUN) run_cycles <= run_cycles + 32'd1;
    end

endmodule

// File: tb/tb_np_mem.sv
// tb_np_mem: randomized directed bench for np_mem.
// A cycle-level reference model predicts every registered output.
module tb_np_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] in_address;
    logic        in_wr;
    logic [31:0] in_dataOut;
    logic [31:0] in_dataIn;
    logic [11:0] address;
    logic        wr;
    logic [31:0] dataOut;
    logic [31:0] dataIn;
    logic        halt;
    logic        cpu_reset;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_target;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        done;
    logic [31:0] run_cycles;

    np_mem dut (
        .clk        (clk),
        .reset      (reset),
        .in_address (in_address),
        .in_wr      (in_wr),
        .in_dataOut (in_dataOut),
        .in_dataIn  (in_dataIn),
        .address    (address),
        .wr         (wr),
        .dataOut    (dataOut),
        .dataIn     (dataIn),
        .halt       (halt),
        .cpu_reset  (cpu_reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_target  (ld_target),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .done       (done),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    // Model: addresses stay within 0..31; known bits mark written words.
    logic [31:0] mi [32];
    logic [31:0] md [32];
    bit          mik [32];
    bit          mdk [32];
    int          phase = -1;
    logic [31:0] mrun = '0;
    int          total = 0;
    int          passed = 0;
    int          failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] ei, ed;
        bit          ki, kd;
        int          ia, da, la;
        ia = int'(in_address[4:0]);
        da = int'(address[4:0]);
        la = int'(ld_addr[4:0]);
        ei = reset ? 32'd0 : mi[ia];
        ki = reset || mik[ia];
        ed = reset ? 32'd0 : md[da];
        kd = reset || mdk[da];
        if (reset) begin
            phase = 0;
            mrun  = '0;
        end else if (phase == 0) begin
            if (ld_valid) begin
                if (ld_target) begin md[la] = ld_data; mdk[la] = 1; end
                else           begin mi[la] = ld_data; mik[la] = 1; end
                if (ld_last) phase = 1;
            end
        end else if (phase == 1) begin
            if (wr)    begin md[da] = dataOut;    mdk[da] = 1; end
            if (in_wr) begin mi[ia] = in_dataOut; mik[ia] = 1; end
            mrun = mrun + 32'd1;
            if (halt) phase = 2;
        end
        @(posedge clk);
        #1;
        if (ki) chk("in_dataIn", in_dataIn, ei);
        if (kd) chk("dataIn", dataIn, ed);
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, phase == 0});
        chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, phase == 0});
        chk("done", {31'd0, done}, {31'd0, phase == 2});
        chk("run_cycles", run_cycles, mrun);
    endtask

    task automatic rnd_reads();
        in_address = 12'($urandom_range(0, 31));
        address    = 12'($urandom_range(0, 31));
    endtask

    task automatic beat(input bit tgt, input int a, input logic [31:0] d,
                        input bit last);
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            ld_valid  = 0;
            halt      = 1'($urandom_range(0, 1));
            ld_target = 1'($urandom_range(0, 1));
            ld_addr   = 12'($urandom_range(0, 31));
            ld_data   = $urandom;
            ld_last   = 1'($urandom_range(0, 1));
            rnd_reads();
            tick();
        end
        halt      = 1'($urandom_range(0, 1));
        ld_valid  = 1;
        ld_target = tgt;
        ld_addr   = 12'(a);
        ld_data   = d;
        ld_last   = last;
        rnd_reads();
        tick();
        ld_valid = 0;
        ld_last  = 0;
        halt     = 0;
    endtask

    initial begin
        reset = 1; in_address = 0; in_wr = 0; in_dataOut = 0;
        address = 0; wr = 0; dataOut = 0; halt = 0;
        ld_valid = 0; ld_target = 0; ld_addr = 0; ld_data = 0; ld_last = 0;
        tick();
        tick();
        reset = 0;

        // Load with gaps and stray halt pulses.
        for (int i = 0; i < 32; i++) beat(1, i, $urandom, 0);
        for (int i = 2; i < 32; i++) beat(0, i, $urandom, 0);
        beat(0, 0, 32'h3000_1000, 0);
        chk("still_load", {31'd0, cpu_reset}, 32'd1);
        beat(0, 1, 32'hB000_0000, 1);
        chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        in_address = 1;
        tick();
        chk("imem1", in_dataIn, 32'hB000_0000);

        // Back-to-back writes to one address keep the last.
        wr = 1; address = 5; dataOut = 32'hFFFF;
        tick();
        dataOut = 32'h1234;
        tick();
        wr = 0;
        tick();
        chk("dmem5", dataIn, 32'h1234);

        // Read-during-write returns old data.
        wr = 1; address = 12'h010; dataOut = 32'hA;
        tick();
        dataOut = 32'hB;
        tick();
        chk("rdw_old", dataIn, 32'hA);
        wr = 0;
        tick();
        chk("rdw_new", dataIn, 32'hB);

        // Random CPU traffic up to the 100th RUN clock, which carries halt.
        while (mrun < 32'd99) begin
            rnd_reads();
            wr         = 1'($urandom_range(0, 1));
            dataOut    = $urandom;
            in_wr      = 1'($urandom_range(0, 1));
            in_address = 12'($urandom_range(2, 31));
            in_dataOut = $urandom;
            if (address == 12'd5) wr = 0;
            tick();
        end
        wr = 0; in_wr = 0; halt = 1;
        rnd_reads();
        tick();
        halt = 0;
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_cycles", run_cycles, 32'd100);

        // CPU writes ignored once halted.
        for (int i = 0; i < 6; i++) begin
            wr = 1; address = 5; dataOut = $urandom;
            in_wr = 1; in_address = 12'($urandom_range(0, 31));
            in_dataOut = $urandom;
            tick();
        end
        wr = 0; in_wr = 0; address = 5;
        tick();
        chk("halt_dmem5", dataIn, 32'h1234);
        chk("halt_frozen", run_cycles, 32'd100);

        // Reload, run briefly, then reset mid-RUN with a beat pending.
        reset = 1;
        tick();
        reset = 0;
        beat(1, 20, $urandom, 1);
        for (int i = 0; i < 5; i++) begin
            rnd_reads();
            tick();
        end
        reset = 1; ld_valid = 1; ld_target = 0; ld_addr = 0;
        ld_data = 32'hDEAD_BEEF; ld_last = 1;
        tick();
        chk("rst_cycles", run_cycles, 32'd0);
        reset = 0; ld_valid = 0; ld_last = 0; in_address = 0;
        tick();
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("rst_imem0", in_dataIn, 32'h3000_1000);
        in_address = 1;
        tick();
        chk("rst_imem1", in_dataIn, 32'hB000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
